sram_fifo_out_queue: RTL and testbench
======================================

Name: sram_fifo_out_queue

Overview:
Per-queue output stage downstream of the SRAM FIFO read arbiter. It consumes one queue's slice of the arbiter's packed word stream (valid-only, no backpressure) and buffers it in a small first-word-fall-through FIFO. It unpacks each word into an AXI4-Stream master beat. It returns an early `full` to the arbiter so that in-flight SRAM reads always land. One instance exists per queue.

Parameters:
- TDATA_WIDTH, 32, AXI data bus width in bytes (W).
- DEPTH, 16, buffer entries; power of 2, at least FULL_HEADROOM+2.
- ADDR_WIDTH, 4, log2(DEPTH).
- FULL_HEADROOM, 6, free entries reserved for words already in flight when `full` asserts.

Ports:
- clk  in  1  Memory-side clock; all logic is on this clock.
- reset  in  1  Synchronous, active-high reset.
- din_valid  in  1  Arbiter word valid for this queue; there is no ready signal.
- din  in  8*W+9  Packed word: [8W-1:0] data, [8W+7:8W] nbytes, [8W+8] last.
- full  out  1  Throttle to arbiter; high when occupancy >= DEPTH-FULL_HEADROOM.
- overflow  out  1  Sticky flag; set when any word is truncated or dropped.
- m_axis_tdata  out  8*W  AXIS data.
- m_axis_tkeep  out  W  AXIS byte enables.
- m_axis_tlast  out  1  AXIS end of packet.
- m_axis_tvalid  out  1  AXIS valid.
- m_axis_tready  in  1  AXIS ready.

Behaviour:
- Reset values:
  - Occupancy, read and write pointers = 0.
  - full = 0, overflow = 0, m_axis_tvalid = 0.
  - State = PASS.
  - Data outputs are don't-care while tvalid = 0.
- Storage:
  - DEPTH x (8W+9) register or distributed RAM, first-word fall-through.
  - m_axis_tvalid = (occupancy != 0).
  - tdata, tlast and tkeep decode from the head entry combinationally.
- Latency: a word written at edge N into an empty buffer gives tvalid = 1 in the cycle after edge N (1 cycle).
- Pop: on tvalid && tready at a rising edge.
- Simultaneous push and pop: occupancy unchanged. Pointers wrap modulo DEPTH.
- tkeep decode:
  - Non-last beat: all ones.
  - Last beat: the low nbytes bits are set.
  - nbytes = 0 or nbytes >= W means all ones.
- full:
  - Registered from next-cycle occupancy.
  - Deasserts as soon as occupancy drops below the threshold; no hysteresis.
- State machine (input side):
  - PASS, push allowed:
    - occupancy < DEPTH-1: store the word as-is.
    - occupancy == DEPTH-1 and last = 1: store as-is.
    - occupancy == DEPTH-1 and last = 0: store with last forced to 1, nbytes forced to 0 (full beat), set overflow, go to DISCARD.
    - occupancy == DEPTH (only after a truncate-free fill): drop the word and set overflow. If last = 0, go to DISCARD; otherwise stay in PASS.
  - DISCARD: drop every din_valid word. A word with last = 1 is dropped and returns the state to PASS on the next cycle.
- A pop in the same cycle frees a slot: compare against occupancy after the pop. Example: occupancy == DEPTH with a pop means the word is accepted normally.
- overflow clears only on reset.
- Reset mid-packet: contents are discarded, state returns to PASS, and the next word is treated as a packet start.
- The AXIS master holds tdata/tkeep/tlast stable while tvalid && !tready.

Optional Feature:
- Macro SRAM_FIFO_OUT_STATS_EN.
- Defined: adds outputs pkt_count[31:0] and drop_count[31:0].
  - pkt_count increments on each AXIS handshake with tlast = 1.
  - drop_count increments per dropped din word (DISCARD or at-capacity drop); a truncated write counts 0.
  - Both counters are wrapping and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single packet: tready = 1, 3 words with last on word 3 and nbytes = 5 → tvalid rises 1 cycle after the first write; 3 beats; beat 3 has tlast = 1 and tkeep = 0x0000001F; full stays 0.
- full threshold: tready = 0, push 10 words with DEPTH = 16 → full = 1 on the cycle after the 10th write. Pop 1 → full = 0 one cycle later.
- Truncation: tready = 0, fill 15 words of one packet, push a 16th non-last word, then 4 more ending in last → the 16th word is stored with tlast = 1 and tkeep all ones; the 4 words are dropped; overflow = 1; drop_count = 4 with STATS_EN. Then push a new 1-word packet while draining → delivered intact.
- Push/pop at capacity: occupancy 16, tready = 1 and din_valid in the same cycle → word accepted, occupancy stays 16, overflow stays 0.
- Backpressure and wrap: random tready at 50%, 100 packets of random length 1–8 → output equals input exactly, tdata stable while stalled, pointers wrap without loss, pkt_count = 100.
- Reset mid-packet: assert reset during the 2nd of 4 words → tvalid = 0 and overflow = 0 next cycle; the following words are accepted as a new packet.

Source files
------------

// File: rtl/sram_fifo_out_queue.sv
// Per-queue output stage: FWFT buffer fed by the SRAM read arbiter, unpacked into AXI4-Stream beats.
// Optional `SRAM_FIFO_OUT_STATS_EN adds pkt_count/drop_count statistics outputs.
module sram_fifo_out_queue #(
  parameter int TDATA_WIDTH   = 32,
  parameter int DEPTH         = 16,
  parameter int ADDR_WIDTH    = 4,
  parameter int FULL_HEADROOM = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       din_valid,
  input  logic [8*TDATA_WIDTH+8:0]   din,
  output logic                       full,
  output logic                       overflow,
  output logic [8*TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [TDATA_WIDTH-1:0]     m_axis_tkeep,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready
`ifdef SRAM_FIFO_OUT_STATS_EN
  ,
  output logic [31:0]                pkt_count,
  output logic [31:0]                drop_count
`endif
);

  localparam int DW = 8 * TDATA_WIDTH;
  localparam int WW = DW + 9;
  localparam logic [ADDR_WIDTH:0] CAP     = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CAP_M1  = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] FULL_AT = (ADDR_WIDTH+1)'(DEPTH - FULL_HEADROOM);

  typedef enum logic {ST_PASS = 1'b0, ST_DISCARD = 1'b1} state_t;

  logic [WW-1:0]         r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_full;
  logic                  r_overflow;
  state_t                r_state;

  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_set_ovf;
  logic [WW-1:0]         w_word;
  logic [WW-1:0]         w_head;
  logic [ADDR_WIDTH:0]   w_occ_after_pop;
  logic [ADDR_WIDTH:0]   w_count_nxt;
  state_t                w_state_nxt;

  // Last beat keeps only its low nbytes lanes; 0 or >= W means a full beat.
  function automatic logic [TDATA_WIDTH-1:0] keep_decode(input logic last, input logic [7:0] nb);
    logic [TDATA_WIDTH-1:0] k;
    k = {TDATA_WIDTH{1'b1}};
    if (last && (nb != 8'd0) && (32'(nb) < 32'(TDATA_WIDTH))) begin
      k = ~({TDATA_WIDTH{1'b1}} << nb);
    end else begin
      k = {TDATA_WIDTH{1'b1}};
    end
    return k;
  endfunction

  assign w_pop           = m_axis_tvalid && m_axis_tready;
  assign w_occ_after_pop = r_count - {{ADDR_WIDTH{1'b0}}, w_pop};
  assign w_count_nxt     = w_occ_after_pop + {{ADDR_WIDTH{1'b0}}, w_push};

  // Input-side admission: store, truncate, or drop, judged against post-pop occupancy.
  always_comb begin
    w_push      = 1'b0;
    w_drop      = 1'b0;
    w_set_ovf   = 1'b0;
    w_word      = din;
    w_state_nxt = r_state;
    case (r_state)
      ST_PASS: begin
        if (!din_valid) begin
          w_push = 1'b0;
        end else if (w_occ_after_pop < CAP_M1) begin
          w_push = 1'b1;
        end else if (w_occ_after_pop == CAP_M1) begin
          w_push = 1'b1;
          if (!din[DW+8]) begin
            w_word[DW+8]    = 1'b1;
            w_word[DW+7:DW] = 8'd0;
            w_set_ovf       = 1'b1;
            w_state_nxt     = ST_DISCARD;
          end else begin
            w_set_ovf = 1'b0;
          end
        end else begin
          w_drop    = 1'b1;
          w_set_ovf = 1'b1;
          if (!din[DW+8]) begin
            w_state_nxt = ST_DISCARD;
          end else begin
            w_state_nxt = ST_PASS;
          end
        end
      end
      ST_DISCARD: begin
        if (din_valid) begin
          w_drop = 1'b1;
          if (din[DW+8]) begin
            w_state_nxt = ST_PASS;
          end else begin
            w_state_nxt = ST_DISCARD;
          end
        end else begin
          w_drop = 1'b0;
        end
      end
      default: w_state_nxt = ST_PASS;
    endcase
  end

  // Control state: pointers, occupancy, early full, sticky overflow, FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= {ADDR_WIDTH{1'b0}};
      r_rd_ptr   <= {ADDR_WIDTH{1'b0}};
      r_count    <= {(ADDR_WIDTH+1){1'b0}};
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
      r_state    <= ST_PASS;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      end
      r_count    <= w_count_nxt;
      r_full     <= (w_count_nxt >= FULL_AT);
      r_overflow <= r_overflow | w_set_ovf;
      r_state    <= w_state_nxt;
    end
  end

  // Storage array; no reset so it can map to distributed RAM.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  assign w_head        = r_mem[r_rd_ptr];
  assign m_axis_tvalid = (r_count != {(ADDR_WIDTH+1){1'b0}});
  assign m_axis_tdata  = w_head[DW-1:0];
  assign m_axis_tlast  = w_head[DW+8];
  assign m_axis_tkeep  = keep_decode(w_head[DW+8], w_head[DW+7:DW]);
  assign full          = r_full;
  assign overflow      = r_overflow;

`ifdef SRAM_FIFO_OUT_STATS_EN
  logic [31:0] r_pkt_count;
  logic [31:0] r_drop_count;

  // Wrapping packet and dropped-word counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pkt_count  <= 32'd0;
      r_drop_count <= 32'd0;
    end else begin
      if (w_pop && m_axis_tlast) begin
        r_pkt_count <= r_pkt_count + 32'd1;
      end
      if (w_drop) begin
        r_drop_count <= r_drop_count + 32'd1;
      end
    end
  end

  assign pkt_count  = r_pkt_count;
  assign drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_sram_fifo_out_queue.sv
// Directed self-checking bench for sram_fifo_out_queue (default parameters, W = 32 bytes).
module tb_sram_fifo_out_queue;

  localparam int W  = 32;
  localparam int DW = 8 * W;

  logic          clk = 1'b0;
  logic          reset;
  logic          din_valid;
  logic [DW+8:0] din;
  logic          full;
  logic          overflow;
  logic [DW-1:0] m_axis_tdata;
  logic [W-1:0]  m_axis_tkeep;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
`ifdef SRAM_FIFO_OUT_STATS_EN
  logic [31:0]   pkt_count;
  logic [31:0]   drop_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [319:0] exp_q[$];
  logic         drv_done;
  logic [319:0] obs_beat;

  sram_fifo_out_queue dut (
    .clk           (clk),
    .reset         (reset),
    .din_valid     (din_valid),
    .din           (din),
    .full          (full),
    .overflow      (overflow),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
`ifdef SRAM_FIFO_OUT_STATS_EN
    ,
    .pkt_count     (pkt_count),
    .drop_count    (drop_count)
`endif
  );

  always #5 clk = ~clk;

  assign obs_beat = {31'd0, m_axis_tlast, m_axis_tkeep, m_axis_tdata};

  task automatic check(input string tag, input logic [319:0] act, input logic [319:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mkdata(input int v);
    return {8{v[31:0]}};
  endfunction

  function automatic logic [31:0] model_keep(input logic [7:0] nb, input logic last);
    if (!last || nb == 8'd0 || nb >= 8'd32) return 32'hFFFF_FFFF;
    return (32'h1 << nb) - 32'h1;
  endfunction

  function automatic logic [319:0] exp_beat(input int v, input logic [7:0] nb, input logic last);
    return {31'd0, last, model_keep(nb, last), mkdata(v)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int v, input logic [7:0] nb, input logic last);
    din_valid = 1'b1;
    din       = {last, nb, mkdata(v)};
  endtask

  task automatic push(input int v, input logic [7:0] nb, input logic last);
    set_word(v, nb, last);
    tick();
    din_valid = 1'b0;
  endtask

  task automatic do_reset;
    reset     = 1'b1;
    din_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; din_valid = 1'b0; din = '0; m_axis_tready = 1'b0; drv_done = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);

    // Single packet, streaming straight through
    m_axis_tready = 1'b1;
    set_word(1, 8'd0, 1'b0); tick();
    check("sp_tvalid_lat", m_axis_tvalid, 1);
    check("sp_beat1", obs_beat, exp_beat(1, 8'd0, 1'b0));
    set_word(2, 8'd0, 1'b0); tick();
    check("sp_beat2", obs_beat, exp_beat(2, 8'd0, 1'b0));
    set_word(3, 8'd5, 1'b1); tick();
    check("sp_beat3", obs_beat, exp_beat(3, 8'd5, 1'b1));
    check("sp_tkeep3", m_axis_tkeep, 32'h0000_001F);
    din_valid = 1'b0; tick();
    check("sp_empty", m_axis_tvalid, 0);
    check("sp_full", full, 0);

    // Full threshold
    do_reset();
    m_axis_tready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      push(i, 8'd0, 1'b1);
      if (i == 9) check("thr_full9", full, 0);
    end
    check("thr_full10", full, 1);
    m_axis_tready = 1'b1; tick(); m_axis_tready = 1'b0;
    check("thr_full_pop", full, 0);

    // Truncation at DEPTH-1 then discard
    do_reset();
    for (int i = 0; i < 15; i++) push(100 + i, 8'd0, 1'b0);
    push(115, 8'd9, 1'b0);
    for (int i = 0; i < 4; i++) push(200 + i, 8'd3, i == 3);
    check("tr_overflow", overflow, 1);
    check("tr_full", full, 1);
`ifdef SRAM_FIFO_OUT_STATS_EN
    check("tr_drop_count", drop_count, 4);
`endif
    m_axis_tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i < 15) check("tr_beat", obs_beat, exp_beat(100 + i, 8'd0, 1'b0));
      else        check("tr_beat_trunc", obs_beat, exp_beat(115, 8'd0, 1'b1));
      if (i == 2) set_word(300, 8'd3, 1'b1);
      tick();
      din_valid = 1'b0;
    end
    check("tr_newpkt", obs_beat, exp_beat(300, 8'd3, 1'b1));
    tick();
    check("tr_empty", m_axis_tvalid, 0);
    m_axis_tready = 1'b0;

    // Push and pop together at capacity, then a drop at capacity
    do_reset();
    for (int i = 0; i < 16; i++) push(400 + i, 8'd0, 1'b1);
    check("cap_full", full, 1);
    m_axis_tready = 1'b1;
    set_word(500, 8'd4, 1'b1); tick();
    din_valid = 1'b0; m_axis_tready = 1'b0;
    check("cap_no_ovf", overflow, 0);
    check("cap_still_full", full, 1);
    push(600, 8'd0, 1'b1);
    check("cap_drop_ovf", overflow, 1);
`ifdef SRAM_FIFO_OUT_STATS_EN
    check("cap_drop_count", drop_count, 1);
`endif
    m_axis_tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i < 15) check("cap_beat", obs_beat, exp_beat(401 + i, 8'd0, 1'b1));
      else        check("cap_beat_last", obs_beat, exp_beat(500, 8'd4, 1'b1));
      tick();
    end
    check("cap_empty", m_axis_tvalid, 0);
`ifdef SRAM_FIFO_OUT_STATS_EN
    check("cap_pkt_count", pkt_count, 17);
`endif
    m_axis_tready = 1'b0;

    // Reset in the middle of a packet
    set_word(700, 8'd0, 1'b0); tick();
    set_word(701, 8'd0, 1'b0); reset = 1'b1; tick();
    reset = 1'b0; din_valid = 1'b0;
    check("mr_tvalid", m_axis_tvalid, 0);
    check("mr_overflow", overflow, 0);
    check("mr_full", full, 0);
    push(702, 8'd0, 1'b0);
    push(703, 8'd2, 1'b1);
    m_axis_tready = 1'b1;
    check("mr_beat1", obs_beat, exp_beat(702, 8'd0, 1'b0));
    tick();
    check("mr_beat2", obs_beat, exp_beat(703, 8'd2, 1'b1));
    tick();
    check("mr_empty", m_axis_tvalid, 0);
    m_axis_tready = 1'b0;

    // Random backpressure, 100 packets
    do_reset();
    fork
      begin
        for (int p = 0; p < 100; p++) begin
          int len;
          len = $urandom_range(1, 8);
          for (int b = 0; b < len; b++) begin
            int guard;
            logic [7:0] nb;
            guard = 0;
            while (full && guard < 2000) begin
              tick();
              guard++;
            end
            if (full) check("rnd_full_timeout", full, 0);
            nb = 8'($urandom_range(0, 40));
            exp_q.push_back(exp_beat(1000 + p * 16 + b, nb, b == len - 1));
            set_word(1000 + p * 16 + b, nb, b == len - 1);
            tick();
            din_valid = 1'b0;
            if ($urandom_range(0, 3) == 0) tick();
          end
        end
        drv_done = 1'b1;
      end
      begin
        logic         stall;
        logic [319:0] prev;
        stall = 1'b0;
        prev  = '0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
          if (drv_done && exp_q.size() == 0) break;
          m_axis_tready = 1'($urandom_range(0, 1));
          @(negedge clk);
          if (stall) check("rnd_stable", obs_beat, prev);
          if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) check("rnd_extra_beat", obs_beat, '0);
            else check("rnd_beat", obs_beat, exp_q.pop_front());
          end
          stall = m_axis_tvalid && !m_axis_tready;
          prev  = obs_beat;
          tick();
        end
      end
    join
    check("rnd_drained", 320'(exp_q.size()), 0);
    check("rnd_overflow", overflow, 0);
`ifdef SRAM_FIFO_OUT_STATS_EN
    check("rnd_pkt_count", pkt_count, 100);
    check("rnd_drop_count", drop_count, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
